// File: rtl/seg_scan_ctrl_if.sv
// Display-scan bus: value loading from the host side, and digit drive toward the
// shared 7-segment decoder and the digit enables.
interface seg_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    blank_lz;
  logic [3:0]              digit_nibble;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    pending;
  logic                    frame_done;

  modport master (
    output load, value, blank_lz,
    input  digit_nibble, digit_sel, pending, frame_done
  );

  modport slave (
    input  load, value, blank_lz,
    output digit_nibble, digit_sel, pending, frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex display scanner: drives one digit at a time with guard gaps between
// digits, and double-buffers new values so they are only committed at a frame wrap.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned DIV        = 50000,
  parameter int unsigned GUARD      = 2
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CntMax    = (DIV > GUARD) ? DIV : GUARD;
  localparam int unsigned CntW      = $clog2(CntMax);
  localparam int unsigned IdxW      = $clog2(NUM_DIGITS);
  localparam int unsigned GuardEnd  = (GUARD == 0) ? 0 : GUARD - 1;

  localparam logic [CntW-1:0] DivLast   = CntW'(DIV - 1);
  localparam logic [CntW-1:0] GuardLast = CntW'(GuardEnd);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic {StOn, StOff} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;

  logic advance;
  logic wrap;
  logic blanked;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StOn;
      cnt_q     <= '0;
      idx_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    advance = 1'b0;
    unique case (state_q)
      StOn: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (GUARD == 0) begin
            advance = 1'b1;
          end else begin
            state_d = StOff;
          end
        end
      end
      StOff: begin
        if (cnt_q == GuardLast) begin
          cnt_d   = '0;
          state_d = StOn;
          advance = 1'b1;
        end
      end
      default: begin
        state_d = StOn;
        cnt_d   = '0;
      end
    endcase

    idx_d = idx_q;
    if (advance) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
    wrap = advance && (idx_q == IdxLast);

    // A load on the wrap edge commits the old shadow and keeps the new one pending.
    active_d  = (wrap && pending_q) ? shadow_q : active_q;
    shadow_d  = bus.load ? bus.value : shadow_q;
    pending_d = bus.load ? 1'b1 : (wrap ? 1'b0 : pending_q);
  end

  always_comb begin
    blanked = bus.blank_lz && (idx_q != '0) && ((active_q >> {idx_q, 2'b00}) == '0);

    bus.digit_sel = '0;
    if (!rst && (state_q == StOn) && !blanked) begin
      bus.digit_sel[idx_q] = 1'b1;
    end
    bus.digit_nibble = active_q[{idx_q, 2'b00} +: 4];
    bus.frame_done   = wrap && !rst;
    bus.pending      = pending_q;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed digits (2..8).
REQ-002 SHALL have parameter DIV, default 50000, meaning clock cycles each digit is driven (>=2).
REQ-003 SHALL have parameter GUARD, default 2, meaning all-off cycles between digits for anti-ghosting (0 allowed).
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-006 SHALL have port load  input  1  single-cycle strobe capturing value into shadow register.
REQ-007 SHALL have port value  input  4*NUM_DIGITS  packed hex digits, digit 0 in bits [3:0].
REQ-008 SHALL have port blank_lz  input  1  enables leading-zero blanking.
REQ-009 SHALL have port digit_nibble  output  4  hex code of the current digit, fed to the shared 7-segment decoder.
REQ-010 SHALL have port digit_sel  output  NUM_DIGITS  one-hot active-high digit enable.
REQ-011 SHALL have port pending  output  1  shadow holds a value not yet committed.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at every frame wrap.

Function
REQ-013 SHALL hold state: ON/OFF FSM, cycle counter cnt, digit index idx, active register, shadow register, pending flag.
REQ-014 In ON, cnt SHALL count 0..DIV-1; at cnt=DIV-1 go to OFF with cnt=0 (GUARD>0), or advance idx and stay ON with cnt=0 (GUARD=0).
REQ-015 In OFF, cnt SHALL count 0..GUARD-1; at GUARD-1 advance idx, go to ON, cnt=0.
REQ-016 idx SHALL advance by 1, wrapping NUM_DIGITS-1 -> 0; a digit period is DIV+GUARD cycles, a frame NUM_DIGITS*(DIV+GUARD).
REQ-017 On wrap cycle frame_done SHALL be 1 for exactly that cycle; if pending=1, active <= shadow and pending clears.
REQ-018 load=1 SHALL write shadow <= value and set pending=1 on the same edge; load never touches active directly.
REQ-019 load coinciding with a wrap SHALL commit the pre-edge shadow to active, store the new value in shadow, and leave pending=1.
REQ-020 Back-to-back loads SHALL overwrite shadow; only the last before a wrap commits.
REQ-021 digit_nibble SHALL equal active[4*idx+3:4*idx] combinationally in both states.
REQ-022 digit_sel SHALL be one-hot bit idx in ON, all-zero in OFF, all-zero for a blanked digit.
REQ-023 Digit idx SHALL be blanked iff blank_lz=1, idx!=0, and active digits idx..NUM_DIGITS-1 are all zero; digit 0 never blanks.
REQ-024 blank_lz changes SHALL take effect combinationally without disturbing scan timing.

Reset
REQ-025 rst=1 SHALL asynchronously force state=ON, cnt=0, idx=0, active=0, shadow=0, pending=0.
REQ-026 While rst=1 digit_sel SHALL be 0, frame_done 0, digit_nibble 0, pending 0.
REQ-027 Reset mid-frame or mid-load SHALL discard shadow and active; first cycle after release digit_sel=0001 with cnt=0.

Verification (NUM_DIGITS=4, DIV=4, GUARD=2)
REQ-028 Release reset, no load -> digit_sel 0001 x4, 0000 x2, 0010 x4, ...; frame_done pulses every 24 cycles; digit_nibble=0.
REQ-029 load value=16'h12AB mid-frame -> pending=1, display unchanged until wrap; after wrap, nibbles B,A,2,1 for idx 0..3, pending=0.
REQ-030 blank_lz=1, commit 16'h0007 -> digit 0 shows 7 with digit_sel=0001; digits 1..3 digit_sel=0000; frame timing unchanged.
REQ-031 load 16'h1111 then 16'h2222 before wrap -> after wrap only 2222 displayed; 1111 never appears.
REQ-032 load 16'h3333 exactly on wrap cycle with shadow=16'h4444 pending -> active=4444, shadow=3333, pending=1; next wrap active=3333.
REQ-033 Assert rst during OFF of idx 2 with pending=1 -> immediate digit_sel=0000, pending=0; after release scan restarts at idx 0, nibbles 0.
